// File: rtl/float_pcm_stream_pkg.sv
// float_pcm_stream_pkg
// Shared single-precision float definitions for the batch filter output path.
// Provides the binary32 field widths, the packed floatType layout
// {sign, exponent[7:0] (bias 127), mantissa[22:0]}, an unpack helper that
// reinterprets a raw word as floatType, and the isNaN/isInf/isZero classifiers.
// isZero treats denormals as zero because the converter flushes them.
// No ports: package only.

package float_pcm_stream_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int BIAS    = 127;
    localparam int FLOAT_W = 1 + EXP_W + MANT_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } floatType;

    function automatic floatType unpack(input logic [FLOAT_W-1:0] raw);
        return floatType'(raw);
    endfunction

    function automatic logic isNaN(input floatType f);
        return (f.exponent == '1) && (f.mantissa != '0);
    endfunction

    function automatic logic isInf(input floatType f);
        return (f.exponent == '1) && (f.mantissa == '0);
    endfunction

    function automatic logic isZero(input floatType f);
        return (f.exponent == '0);
    endfunction

endpackage

// File: rtl/float_pcm_stream_fifo_sync.sv
// fifo_sync
// Synchronous FIFO with a registered head entry.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   push, din  write request and data; a push into a full FIFO is only
//              accepted when a pop happens in the same cycle
//   pop        read request; ignored while empty
//   dout       registered head entry (0 while empty)
//   full       level == DEPTH
//   empty      level == 0
//   level      occupancy, write pointer minus read pointer

module fifo_sync
    import float_pcm_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] level_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PTR_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // The head register must show the entry that becomes the head after this
    // edge. When the FIFO drains to exactly the incoming word, that word has
    // not reached mem yet, so it is bypassed straight from din.
    always_comb begin
        rd_next    = rd_ptr + PTR_W'(do_pop);
        level_next = level - PTR_W'(do_pop) + PTR_W'(do_push);
        head_next  = '0;
        if (level_next == '0) begin
            head_next = '0;
        end else if (do_push && (rd_next == wr_ptr)) begin
            head_next = din;
        end else begin
            head_next = mem[rd_next[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_next;
            dout   <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/float_pcm_stream.sv
// float_pcm_stream
// Decimates a stream of binary32 filter results, converts the kept samples to
// signed fixed-point PCM (round to nearest, ties away from zero, saturating)
// and buffers them in a FIFO drained over valid/ready.
// Ports:
//   clk, rst             clock and synchronous active-low reset
//   in_data, in_valid    one float per valid cycle, no backpressure
//   out_data, out_valid  FIFO head and non-empty indication
//   out_ready            consumer accepts the head when out_valid is high
//   level                FIFO occupancy
//   sat_flag             sticky: a kept sample saturated or was NaN
//   ovf_flag             sticky: a converted sample hit a full FIFO and was lost
//   clr_flags            clears both flags; a new event in the same cycle wins

module float_pcm_stream
    import float_pcm_stream_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int OUT_W      = 16,
    parameter int FRAC       = 14,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$bits(floatType)-1:0]   in_data,
    input  logic                          in_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    input  logic                          clr_flags
);

    localparam int PHASE_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    // One spare magnitude bit so +2^(OUT_W-1) (valid when negative) fits.
    localparam int MAG_W     = OUT_W + 1;
    localparam int SHIFT_OFS = FRAC - MANT_W - BIAS;

    localparam logic [MAG_W:0]   MAX_POS  = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [MAG_W:0]   MAX_NEG  = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] PCM_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] PCM_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PHASE_W-1:0] phase;
    logic               keep;

    floatType           f;
    logic [MANT_W:0]    sig;
    int                 shift;
    logic [5:0]         lsh;
    logic [4:0]         rsh;
    logic [MANT_W+1:0]  ext;
    logic [63:0]        wide;
    logic               s1_ovf_d;
    logic               s1_guard_d;
    logic               s1_nan_d;
    logic [MAG_W-1:0]   s1_mag_d;

    logic               s1_valid;
    logic               s1_sign;
    logic               s1_nan;
    logic               s1_ovf;
    logic               s1_guard;
    logic [MAG_W-1:0]   s1_mag;

    logic [MAG_W:0]     rounded;
    logic [OUT_W-1:0]   s2_data_d;
    logic               sat_d;

    logic               s2_valid;
    logic [OUT_W-1:0]   s2_data;

    logic               fifo_full;
    logic               fifo_empty;
    logic               sat_event;
    logic               drop_event;

    assign keep = in_valid && (phase == '0);

    // Phase only advances on valid cycles so gaps do not disturb decimation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PHASE_W'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Stage 1: scale 1.mant by 2^(exp-127+FRAC-23). Left shifts beyond 40
    // certainly overflow any OUT_W; right shifts beyond 24 leave no integer
    // bits and no guard bit, so both directions are clamped before shifting.
    always_comb begin
        f          = unpack(in_data);
        sig        = {1'b1, f.mantissa};
        shift      = int'(f.exponent) + SHIFT_OFS;
        lsh        = '0;
        rsh        = '0;
        ext        = '0;
        wide       = '0;
        s1_ovf_d   = 1'b0;
        s1_guard_d = 1'b0;
        s1_nan_d   = 1'b0;
        if (isNaN(f)) begin
            s1_nan_d = 1'b1;
        end else if (isInf(f)) begin
            s1_ovf_d = 1'b1;
        end else if (isZero(f)) begin
            wide = '0;
        end else if (shift >= 0) begin
            if (shift > 40) begin
                s1_ovf_d = 1'b1;
            end else begin
                lsh  = 6'(shift);
                wide = 64'(sig) << lsh;
            end
        end else if (shift >= -24) begin
            rsh        = 5'(-shift);
            ext        = {sig, 1'b0} >> rsh;
            wide       = 64'(ext[MANT_W+1:1]);
            s1_guard_d = ext[0];
        end
        s1_ovf_d = s1_ovf_d | (|(wide >> MAG_W));
        s1_mag_d = wide[MAG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nan   <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_guard <= 1'b0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= keep;
            s1_sign  <= f.sign;
            s1_nan   <= s1_nan_d;
            s1_ovf   <= s1_ovf_d;
            s1_guard <= s1_guard_d;
            s1_mag   <= s1_mag_d;
        end
    end

    // Stage 2: adding the guard bit to the magnitude rounds ties away from
    // zero for both signs. Negative values may reach 2^(OUT_W-1) unflagged.
    always_comb begin
        rounded   = {1'b0, s1_mag} + {{MAG_W{1'b0}}, s1_guard};
        s2_data_d = '0;
        sat_d     = 1'b0;
        if (s1_nan) begin
            sat_d = 1'b1;
        end else if (!s1_sign) begin
            if (s1_ovf || (rounded > MAX_POS)) begin
                s2_data_d = PCM_POS;
                sat_d     = 1'b1;
            end else begin
                s2_data_d = rounded[OUT_W-1:0];
            end
        end else begin
            if (s1_ovf || (rounded > MAX_NEG)) begin
                s2_data_d = PCM_NEG;
                sat_d     = 1'b1;
            end else begin
                s2_data_d = -rounded[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_data  <= s2_data_d;
        end
    end

    fifo_sync #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .din   (s2_data),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid  = ~fifo_empty;
    assign sat_event  = s1_valid & sat_d;
    assign drop_event = s2_valid & fifo_full & ~(out_valid & out_ready);

    // Set has priority over clear so an event coinciding with clr is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (sat_event) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop_event) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule
